// File: rtl/rv32i_types.sv
// Shared types for the CPU memory responder: widths, FSM states and the arbiter grant.
package rv32i_types;

    localparam int unsigned width       = 32;
    localparam int unsigned fetch_width = 2 * width;
    localparam int unsigned be_width    = width / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_LO   = 3'd1,
        I_HI   = 3'd2,
        L_RD   = 3'd3,
        L_WR   = 3'd4,
        I_RESP = 3'd5,
        L_RESP = 3'd6
    } resp_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_L = 1'b1
    } grant_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [width-1:0] align_word(input logic [width-1:0] addr);
        return {addr[width-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_mem_responder.sv
// Arbitrates the 64-bit fetch port and the 32-bit LSQ port onto one 32-bit memory port.
module cpu_mem_responder
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [be_width-1:0]    i_mem_byte_enable,
    input  logic [width-1:0]       i_mem_address,
    input  logic [width-1:0]       i_mem_wdata,
    output logic                   i_mem_resp,
    output logic [fetch_width-1:0] i_mem_rdata,

    input  logic                   lsq_mem_read,
    input  logic                   lsq_mem_write,
    input  logic [be_width-1:0]    lsq_mem_byte_enable,
    input  logic [width-1:0]       lsq_mem_address,
    input  logic [width-1:0]       lsq_mem_wdata,
    output logic                   lsq_mem_resp,
    output logic [width-1:0]       lsq_mem_rdata,

    output logic                   mem_read,
    output logic                   mem_write,
    output logic [width-1:0]       mem_address,
    output logic [width-1:0]       mem_wdata,
    output logic [be_width-1:0]    mem_byte_enable,
    input  logic                   mem_resp,
    input  logic [width-1:0]       mem_rdata
);

    resp_state_t            state_q, state_d;
    grant_t                 last_grant_q, last_grant_d;
    logic                   stale_q, stale_d;
    logic [width-1:0]       addr_q, addr_d;
    logic [width-1:0]       wdata_q, wdata_d;
    logic [be_width-1:0]    be_q, be_d;
    logic [fetch_width-1:0] i_rdata_q, i_rdata_d;
    logic [width-1:0]       l_rdata_q, l_rdata_d;

    logic lsq_req;
    logic take_fetch;
    logic fetch_moved;
    logic stale_now;

    // Fetch-port write signals and the low fetch address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{i_mem_write, i_mem_byte_enable, i_mem_wdata, i_mem_address[1:0]};

    // Request decode and redirect detection shared by the next-state logic.
    always_comb begin
        lsq_req     = lsq_mem_read | lsq_mem_write;
        take_fetch  = i_mem_read & (~lsq_req | (last_grant_q == GRANT_L));
        fetch_moved = ~i_mem_read | (i_mem_address[width-1:2] != addr_q[width-1:2]);
        stale_now   = stale_q | fetch_moved;
    end

    // Next-state, grant and capture logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        stale_d      = stale_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        i_rdata_d    = i_rdata_q;
        l_rdata_d    = l_rdata_q;

        case (state_q)
            IDLE: begin
                stale_d = 1'b0;
                if (take_fetch) begin
                    state_d      = I_LO;
                    last_grant_d = GRANT_I;
                    addr_d       = align_word(i_mem_address);
                    wdata_d      = '0;
                    be_d         = '0;
                end else if (lsq_req) begin
                    // A simultaneous read and write is served as a store.
                    state_d      = lsq_mem_write ? L_WR : L_RD;
                    last_grant_d = GRANT_L;
                    addr_d       = lsq_mem_address;
                    wdata_d      = lsq_mem_wdata;
                    be_d         = lsq_mem_byte_enable;
                end
            end
            I_LO: begin
                stale_d = stale_now;
                if (mem_resp) begin
                    i_rdata_d[width-1:0] = mem_rdata;
                    state_d              = stale_now ? IDLE : I_HI;
                end
            end
            I_HI: begin
                stale_d = stale_now;
                if (mem_resp) begin
                    i_rdata_d[fetch_width-1:width] = mem_rdata;
                    state_d                        = stale_now ? IDLE : I_RESP;
                end
            end
            L_RD: begin
                if (mem_resp) begin
                    l_rdata_d = mem_rdata;
                    state_d   = L_RESP;
                end
            end
            L_WR: begin
                if (mem_resp) begin
                    state_d = L_RESP;
                end
            end
            I_RESP:  state_d = IDLE;
            L_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_L;
            stale_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            i_rdata_q    <= '0;
            l_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            stale_q      <= stale_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            i_rdata_q    <= i_rdata_d;
            l_rdata_q    <= l_rdata_d;
        end
    end

    // Outputs come from registers or state decode only; nothing passes through from the requesters.
    always_comb begin
        mem_read        = (state_q == I_LO) | (state_q == I_HI) | (state_q == L_RD);
        mem_write       = (state_q == L_WR);
        mem_address     = (state_q == I_HI) ? addr_q + width'(4) : addr_q;
        mem_wdata       = wdata_q;
        mem_byte_enable = be_q;
        i_mem_resp      = (state_q == I_RESP);
        i_mem_rdata     = i_rdata_q;
        lsq_mem_resp    = (state_q == L_RESP);
        lsq_mem_rdata   = l_rdata_q;
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: behavioural downstream memory with wait states and a reference image.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [3:0]  i_mem_byte_enable = 4'hF;
    logic [31:0] i_mem_address = '0, i_mem_wdata = 32'hCAFEF00D;
    logic        i_mem_resp;
    logic [63:0] i_mem_rdata;
    logic        lsq_mem_read = 1'b0, lsq_mem_write = 1'b0;
    logic [3:0]  lsq_mem_byte_enable = '0;
    logic [31:0] lsq_mem_address = '0, lsq_mem_wdata = '0;
    logic        lsq_mem_resp;
    logic [31:0] lsq_mem_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int unsigned mem_wait = 0;
    int unsigned wcnt = 0;
    logic [31:0] exp_lsq = '0;

    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] log_addr  [$];
    logic        log_wr    [$];

    cpu_mem_responder dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_byte_enable(i_mem_byte_enable), .i_mem_address(i_mem_address),
        .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
        .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
        .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp), .lsq_mem_rdata(lsq_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + a[15:0] + 16'h1234};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Downstream memory: answers after mem_wait extra cycles, decided half a cycle ahead of the edge.
    always @(negedge clk) begin
        if ((mem_read || mem_write) && wcnt >= mem_wait) begin
            mem_resp  = 1'b1;
            mem_rdata = mem_read ? mem_rd(mem_address) : 32'h0BAD0BAD;
        end else begin
            mem_resp  = 1'b0;
            mem_rdata = 32'h0BAD0BAD;
        end
    end

    // Completion bookkeeping for the downstream memory.
    always @(posedge clk) begin
        if (mem_resp && (mem_read || mem_write)) begin
            if (mem_write) mem_store[mem_address] = merge(mem_rd(mem_address), mem_wdata, mem_byte_enable);
            log_addr.push_back(mem_address);
            log_wr.push_back(mem_write);
            wcnt = 0;
        end else if (mem_read || mem_write) begin
            wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b0;
        i_mem_read = 1'b0; lsq_mem_read = 1'b0; lsq_mem_write = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_lsq = '0;
    endtask

    // Issue one fetch starting just after an edge; returns data and latency in cycles.
    task automatic fetch_txn(input logic [31:0] a, output logic [63:0] d, output int lat, output bit got);
        int unsigned c0 = cyc;
        i_mem_read = 1'b1; i_mem_address = a;
        got = 1'b0; lat = 0; d = '0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (i_mem_resp) begin got = 1'b1; lat = int'(cyc - c0); d = i_mem_rdata; end
        end
        @(posedge clk); #1;
        i_mem_read = 1'b0;
    endtask

    task automatic lsq_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] d, output int lat, output bit got);
        int unsigned c0 = cyc;
        lsq_mem_read = rd; lsq_mem_write = wr; lsq_mem_address = a;
        lsq_mem_wdata = wd; lsq_mem_byte_enable = be;
        got = 1'b0; lat = 0; d = '0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (lsq_mem_resp) begin got = 1'b1; lat = int'(cyc - c0); d = lsq_mem_rdata; end
        end
        @(posedge clk); #1;
        lsq_mem_read = 1'b0; lsq_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        i_mem_read = 1'b1; lsq_mem_read = 1'b1; i_mem_address = 32'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_mem_resp, lsq_mem_resp} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, i_mem_resp, lsq_mem_resp});
        end
        checks++;
        if ({i_mem_rdata, lsq_mem_rdata, mem_address, mem_wdata, mem_byte_enable} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero data outputs, expected all zero");
        end
        i_mem_read = 1'b0; lsq_mem_read = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_after_reset: mem_read=%b expected 0", mem_read); end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        logic [63:0] d; int lat; bit got;
        mem_wait = 0; log_addr.delete(); log_wr.delete();
        mem_store[32'h1000] = 32'h11111111; mem_store[32'h1004] = 32'h22222222;
        fetch_txn(32'h1000, d, lat, got);
        checks++;
        if (!got || lat != 3) begin errors++; $display("FAIL fetch_latency: got=%0d lat=%0d expected 3", got, lat); end
        checks++;
        if (d !== 64'h22222222_11111111) begin errors++; $display("FAIL fetch_data: got %h expected 2222222211111111", d); end
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'h1000 || log_addr[1] !== 32'h1004 || log_wr[0] || log_wr[1]) begin
            errors++; $display("FAIL fetch_addrs: %0d accesses, expected reads of 1000 and 1004", log_addr.size());
        end
        @(negedge clk);
        checks++;
        if (i_mem_resp !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: resp=%b expected 0", i_mem_resp); end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [31:0] d; int lat; bit got; int held = 0; int bad = 0;
        mem_wait = 2; log_addr.delete(); log_wr.delete();
        fork
            lsq_txn(1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, d, lat, got);
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                if (mem_write) begin
                    held++;
                    if (mem_address !== 32'h2000 || mem_wdata !== 32'hDEADBEEF || mem_byte_enable !== 4'b0011) bad++;
                end
            end
        join
        checks++;
        if (held != 3 || bad != 0) begin errors++; $display("FAIL store_hold: held=%0d bad=%0d expected 3/0", held, bad); end
        checks++;
        if (!got || lat != 4) begin errors++; $display("FAIL store_latency: got=%0d lat=%0d expected 4", got, lat); end
        checks++;
        if (d !== exp_lsq) begin errors++; $display("FAIL store_rdata: got %h expected %h", d, exp_lsq); end
        checks++;
        if (mem_rd(32'h2000) !== merge(mem_init(32'h2000), 32'hDEADBEEF, 4'b0011)) begin
            errors++; $display("FAIL store_mem: got %h expected %h", mem_rd(32'h2000), merge(mem_init(32'h2000), 32'hDEADBEEF, 4'b0011));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int order[$]; int n_i = 0; bit ir, lr;
        logic [31:0] ld = '0;
        apply_reset();
        mem_wait = 0; log_addr.delete(); log_wr.delete();
        i_mem_read = 1'b1; i_mem_address = 32'h0;
        lsq_mem_read = 1'b1; lsq_mem_write = 1'b0; lsq_mem_address = 32'h40;
        for (int k = 0; k < 60 && order.size() < 3; k++) begin
            @(negedge clk);
            ir = i_mem_resp; lr = lsq_mem_resp;
            if (ir) order.push_back(0);
            if (lr) begin order.push_back(1); ld = lsq_mem_rdata; end
            @(posedge clk); #1;
            if (ir) begin n_i++; if (n_i == 1) i_mem_address = 32'h80; else i_mem_read = 1'b0; end
            if (lr) lsq_mem_read = 1'b0;
        end
        i_mem_read = 1'b0; lsq_mem_read = 1'b0;
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            errors++; $display("FAIL arb_order: %0d responses, expected fetch, load, fetch", order.size());
        end
        checks++;
        if (log_addr.size() != 5 || log_addr[0] !== 32'h0 || log_addr[1] !== 32'h4 || log_addr[2] !== 32'h40
            || log_addr[3] !== 32'h80 || log_addr[4] !== 32'h84) begin
            errors++; $display("FAIL arb_addrs: %0d accesses, expected 0,4,40,80,84", log_addr.size());
        end
        exp_lsq = mem_rd(32'h40);
        checks++;
        if (ld !== exp_lsq) begin errors++; $display("FAIL arb_load_data: got %h expected %h", ld, exp_lsq); end
        @(posedge clk); #1;
    endtask

    task automatic test_stale();
        int unsigned c0; int resp_cnt = 0; int lat = 0; logic [63:0] d = '0;
        mem_wait = 3; log_addr.delete(); log_wr.delete();
        c0 = cyc;
        i_mem_read = 1'b1; i_mem_address = 32'h100;
        @(posedge clk); #1;
        i_mem_address = 32'h200;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (i_mem_resp) begin
                resp_cnt++;
                if (resp_cnt == 1) begin lat = int'(cyc - c0); d = i_mem_rdata; end
            end
            if (resp_cnt == 1 && k > 20) break;
            @(posedge clk); #1;
            if (resp_cnt > 0) i_mem_read = 1'b0;
        end
        i_mem_read = 1'b0;
        checks++;
        if (resp_cnt != 1 || lat != 14) begin errors++; $display("FAIL stale_resp: count=%0d lat=%0d expected 1/14", resp_cnt, lat); end
        checks++;
        if (log_addr.size() != 3 || log_addr[0] !== 32'h100 || log_addr[1] !== 32'h200 || log_addr[2] !== 32'h204) begin
            errors++; $display("FAIL stale_addrs: %0d accesses, expected 100,200,204", log_addr.size());
        end
        checks++;
        if (d !== {mem_rd(32'h204), mem_rd(32'h200)}) begin
            errors++; $display("FAIL stale_data: got %h expected %h", d, {mem_rd(32'h204), mem_rd(32'h200)});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [63:0] d; int lat; bit got;
        mem_wait = 0; log_addr.delete(); log_wr.delete();
        fetch_txn(32'hFFFFFFFC, d, lat, got);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFFFFFC || log_addr[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_addrs: %0d accesses, expected FFFFFFFC then 0", log_addr.size());
        end
        checks++;
        if (!got || d !== {mem_rd(32'h0), mem_rd(32'hFFFFFFFC)}) begin
            errors++; $display("FAIL wrap_data: got %h expected %h", d, {mem_rd(32'h0), mem_rd(32'hFFFFFFFC)});
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; int lat; bit got;
        mem_wait = 2; log_addr.delete(); log_wr.delete();
        i_mem_read = 1'b1; i_mem_address = 32'h3000;
        for (int k = 0; k < 20 && log_addr.size() == 0; k++) @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h3004 || i_mem_rdata[31:0] !== mem_rd(32'h3000)) begin
            errors++; $display("FAIL mid_pre: read=%b addr=%h lo=%h expected 1/3004/%h", mem_read, mem_address, i_mem_rdata[31:0], mem_rd(32'h3000));
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, i_mem_resp} !== 2'b00 || i_mem_rdata !== 64'h0 || mem_address !== 32'h0) begin
            errors++; $display("FAIL mid_async: read=%b resp=%b rdata=%h addr=%h expected zeros", mem_read, i_mem_resp, i_mem_rdata, mem_address);
        end
        i_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_lsq = '0;
        log_addr.delete(); log_wr.delete();
        fetch_txn(32'h3000, d, lat, got);
        checks++;
        if (!got || lat != 7 || d !== {mem_rd(32'h3004), mem_rd(32'h3000)}) begin
            errors++; $display("FAIL mid_restart: got=%0d lat=%0d data=%h expected 7/%h", got, lat, d, {mem_rd(32'h3004), mem_rd(32'h3000)});
        end
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'h3000) begin
            errors++; $display("FAIL mid_restart_addrs: %0d accesses, expected 3000,3004", log_addr.size());
        end
    endtask

    task automatic test_random();
        logic [63:0] fd; logic [31:0] ld, a, wd, e; logic [3:0] be;
        int lat; bit got; int kind; int unsigned w; logic rd;
        apply_reset();
        ref_mem.delete();
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 2);
            w = $urandom_range(0, 2);
            mem_wait = w;
            a = 32'h8000 + 32'($urandom_range(0, 15)) * 32'd4;
            if (kind == 0) begin
                fetch_txn(a | 32'($urandom_range(0, 3)), fd, lat, got);
                checks++;
                if (!got || lat != int'(3 + 2 * w) || fd !== {ref_rd(a + 32'd4), ref_rd(a)}) begin
                    errors++; $display("FAIL rnd_fetch[%0d]: a=%h lat=%0d data=%h expected %0d/%h", t, a, lat, fd, 3 + 2 * w, {ref_rd(a + 32'd4), ref_rd(a)});
                end
            end else if (kind == 1) begin
                lsq_txn(1'b1, 1'b0, a, 32'h0, 4'h0, ld, lat, got);
                exp_lsq = ref_rd(a);
                checks++;
                if (!got || lat != int'(2 + w) || ld !== exp_lsq) begin
                    errors++; $display("FAIL rnd_load[%0d]: a=%h lat=%0d data=%h expected %0d/%h", t, a, lat, ld, 2 + w, exp_lsq);
                end
            end else begin
                wd = $urandom; be = 4'($urandom_range(0, 15)); rd = 1'($urandom_range(0, 1));
                ref_mem[a] = merge(ref_rd(a), wd, be);
                lsq_txn(rd, 1'b1, a, wd, be, ld, lat, got);
                e = ref_rd(a);
                checks++;
                if (!got || lat != int'(2 + w) || ld !== exp_lsq || mem_rd(a) !== e) begin
                    errors++; $display("FAIL rnd_store[%0d]: a=%h lat=%0d rdata=%h mem=%h expected %0d/%h/%h", t, a, lat, ld, mem_rd(a), 2 + w, exp_lsq, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_arbitration();
        test_stale();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the CPU's two memory initiator ports: the 64-bit instruction-fetch port (`i_mem_*`) and the 32-bit load/store-queue port (`lsq_mem_*`). It accepts requests from both ports and arbitrates them round-robin onto a single 32-bit downstream memory port. Each 64-bit fetch is split into two sequential 32-bit reads. One one-cycle response pulse is returned to the requester per completed request. The block sits between `cpu` and the cache/physical-memory model.

## Interface
- `width`, 32, data/address width of every 32-bit bus.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `i_mem_read`  in  1  fetch request, held until `i_mem_resp`.
- `i_mem_write`, `i_mem_byte_enable`, `i_mem_wdata`  in  1/4/32  ignored.
- `i_mem_address`  in  32  fetch address; bits [1:0] treated as 0.
- `i_mem_resp`  out  1  one-cycle completion pulse.
- `i_mem_rdata`  out  64  {word@addr+4, word@addr}.
- `lsq_mem_read`, `lsq_mem_write`  in  1  LSQ request, held until `lsq_mem_resp`.
- `lsq_mem_byte_enable`  in  4  write byte mask.
- `lsq_mem_address`, `lsq_mem_wdata`  in  32  LSQ address and store data.
- `lsq_mem_resp`  out  1  one-cycle completion pulse.
- `lsq_mem_rdata`  out  32  load data.
- `mem_read`, `mem_write`  out  1  downstream request, held until `mem_resp`.
- `mem_address`, `mem_wdata`  out  32  downstream address and store data.
- `mem_byte_enable`  out  4  downstream byte mask.
- `mem_resp`  in  1  downstream completion.
- `mem_rdata`  in  32  downstream read data.

## Operation
- FSM states:
  - `IDLE`
  - `I_LO`: fetch, first word.
  - `I_HI`: fetch, second word.
  - `L_RD`: LSQ load.
  - `L_WR`: LSQ store.
  - `I_RESP`
  - `L_RESP`
- In `IDLE`, if exactly one port requests, grant it. If both request, grant the port not granted last (`last_grant` bit, reset = LSQ, so fetch wins the first tie).
- On grant, latch address (fetch: `{addr[31:2],2'b00}`), wdata and byte_enable.
- LSQ with read and write both high: treat as write.
- `I_LO`: `mem_read=1`, `mem_address`=latched. On `mem_resp`, capture `mem_rdata` into `i_mem_rdata[31:0]` and go to `I_HI`.
- `I_HI`: `mem_address`=latched+4. The address wraps mod 2^32, so 0xFFFFFFFC+4 = 0x0. On `mem_resp`, capture into [63:32] and go to `I_RESP`.
- `L_RD`: `mem_read=1`. On `mem_resp`, capture `lsq_mem_rdata` and go to `L_RESP`.
- `L_WR`: `mem_write=1`, with latched wdata/byte_enable. On `mem_resp`, go to `L_RESP`. `lsq_mem_rdata` is unchanged.
- `I_RESP`/`L_RESP`: the matching resp=1 for exactly one cycle, then `IDLE`.
- Stale fetch (pc redirect): while in `I_LO`/`I_HI`, if `i_mem_read`=0 or `i_mem_address`≠latched, set `stale`.
  - The in-flight downstream access always completes; it is never dropped while `mem_read` is high.
  - After it completes, go straight to `IDLE` with no `i_mem_resp`. `I_HI` is skipped if `stale` is set during `I_LO`.
  - `last_grant` still records fetch.
- LSQ requests are never abandoned. A dropped LSQ request mid-service is a protocol violation; the access completes and resp still pulses.
- Requesters must deassert, or present a new request, in the cycle after their resp. The responder may re-grant the same port from `IDLE` that cycle.

## Timing
- Reset values: state `IDLE`; all outputs 0, including both rdata buses; `stale`=0; `last_grant`=LSQ.
- All outputs are registered or decoded from state only. There is no combinational path from requester inputs to requester outputs.
- Grant takes one cycle: a request visible in `IDLE` cycle N drives the downstream request from cycle N+1.
- With a memory that asserts `mem_resp` in the first request cycle:
  - Fetch: `i_mem_resp` in cycle N+3.
  - Load/store: `lsq_mem_resp` in cycle N+2.
- Each `mem_resp` cycle adds its wait states 1:1.
- Back-to-back throughput: one `IDLE` cycle between consecutive transactions.
- Reset asserted mid-transaction: immediate return to reset values; the downstream request drops asynchronously.

## Structure
- `resp_state_t` enum and `grant_t` (`GRANT_I`, `GRANT_L`) go in `rv32i_types`.
- Single module; no sub-module. The arbiter is one flip-flop and does not justify its own file.

## Test plan
- Fetch 0x1000 with a 0-wait memory returning 0x11111111@0x1000 and 0x22222222@0x1004:
  - Downstream addresses are 0x1000 then 0x1004.
  - `i_mem_rdata`=0x22222222_11111111 with `i_mem_resp` at N+3, one cycle wide.
- LSQ store 0x2000, wdata 0xDEADBEEF, be 4'b0011, memory 2 wait states:
  - `mem_write` is held 3 cycles with the same fields.
  - `lsq_mem_resp` pulses at N+4; `lsq_mem_rdata` stays 0.
- Fetch 0x0 and LSQ load 0x40 both raised in the same cycle after reset:
  - Fetch is served first, then the load.
  - Both raised again: the load goes first.
- Fetch 0x100 with 3 wait states; `i_mem_address` changes to 0x200 during `I_LO`:
  - The downstream read of 0x100 completes.
  - No read of 0x104, no `i_mem_resp`, back to `IDLE`, then 0x200 is served normally.
- Fetch at 0xFFFFFFFC: the second downstream address is 0x00000000.
- `rst`=0 during `I_HI`: `mem_read`, `i_mem_resp` and rdata go to 0 without a clock edge; a fetch after release restarts at `I_LO`.
